// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot_loader byte-stream frame loader.
package boot_loader_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_ADDR_HI = 4'd1;
  localparam state_t S_ADDR_LO = 4'd2;
  localparam state_t S_CNT_HI  = 4'd3;
  localparam state_t S_CNT_LO  = 4'd4;
  localparam state_t S_WORD    = 4'd5;
  localparam state_t S_WRITE   = 4'd6;
  localparam state_t S_CSUM    = 4'd7;
  localparam state_t S_ERROR   = 4'd8;

  localparam logic [7:0] CMD_DATA_DEF = 8'hA5;
  localparam logic [7:0] CMD_INST_DEF = 8'h5A;
  localparam logic [7:0] CMD_RUN_DEF  = 8'hF0;

endpackage

// File: rtl/boot_loader_byte_to_word.sv
// Four-byte MSB-first word assembler; word_done marks the byte that completes a word.
module byte_to_word (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_p0;
  logic [1:0]  cnt_p0;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shift_p0 <= 24'd0;
      cnt_p0   <= 2'd0;
    end else if (load) begin
      shift_p0 <= {shift_p0[15:0], byte_in};
      cnt_p0   <= cnt_p0 + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign word      = {shift_p0, byte_in};
  assign word_done = load && (cnt_p0 == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream loader feeding the CPU load port and owning the CPU reset.
// Optional trailing checksum per segment: define BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] CMD_DATA = CMD_DATA_DEF,
  parameter logic [7:0] CMD_INST = CMD_INST_DEF,
  parameter logic [7:0] CMD_RUN  = CMD_RUN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] address,
  output logic              write_instruction,
  output logic              write_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_IDLE;
`endif

  state_t      state;
  logic [7:0]  addr_hi;
  logic [7:0]  cnt_hi;
  logic [15:0] remaining;
  logic        seg_inst;
  logic        accept;
  logic        new_header;
  logic [15:0] addr_full;
  logic [15:0] cnt_full;
  logic [31:0] word;
  logic        word_done;

  assign accept     = in_valid && in_ready;
  assign new_header = (state == S_IDLE) && accept &&
                      ((in_data == CMD_DATA) || (in_data == CMD_INST));
  assign addr_full  = {addr_hi, in_data};
  assign cnt_full   = {cnt_hi, in_data};

  assign in_ready = rst && (state != S_WRITE) && (state != S_ERROR);
  assign busy     = (state != S_IDLE) && (state != S_ERROR);
  assign error    = (state == S_ERROR);

  byte_to_word u_b2w (
    .clk       (clk),
    .rst       (rst),
    .clear     (new_header),
    .load      (accept && (state == S_WORD)),
    .byte_in   (in_data),
    .word      (word),
    .word_done (word_done)
  );

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rst || new_header) begin
      csum <= 8'd0;
    end else if (accept && busy && (state != S_CSUM)) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      addr_hi           <= 8'd0;
      cnt_hi            <= 8'd0;
      remaining         <= 16'd0;
      seg_inst          <= 1'b0;
      inst_data         <= 32'd0;
      address           <= '0;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      cpu_rst           <= 1'b1;
    end else begin
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (new_header) begin
            seg_inst <= (in_data == CMD_INST);
            cpu_rst  <= 1'b1;
            state    <= S_ADDR_HI;
          end else if (in_data == CMD_RUN) begin
            cpu_rst <= 1'b0;
          end else begin
            cpu_rst <= 1'b1;
            state   <= S_ERROR;
          end
        end
        S_ADDR_HI: if (accept) begin
          addr_hi <= in_data;
          state   <= S_ADDR_LO;
        end
        S_ADDR_LO: if (accept) begin
          address <= addr_full[ADDR_W-1:0];
          state   <= S_CNT_HI;
        end
        S_CNT_HI: if (accept) begin
          cnt_hi <= in_data;
          state  <= S_CNT_LO;
        end
        S_CNT_LO: if (accept) begin
          remaining <= cnt_full;
          state     <= (cnt_full == 16'd0) ? S_END : S_WORD;
        end
        S_WORD: if (word_done) begin
          inst_data         <= word;
          write_instruction <= seg_inst;
          write_data        <= !seg_inst;
          state             <= S_WRITE;
        end
        S_WRITE: begin
          address   <= address + ADDR_W'(1);
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? S_END : S_WORD;
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: if (accept) begin
          state <= (in_data == csum) ? S_IDLE : S_ERROR;
        end
`endif
        S_ERROR: cpu_rst <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
